// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock ratio monitor.
// Latency: n/a (package only).
// Backpressure: none.
package clk_mon_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } mon_state_e;

    localparam int unsigned DEF_RATIO_WIDTH = 5;
    localparam int unsigned DEF_LOCK_COUNT  = 3;
    localparam int unsigned MIN_RATIO       = 2;

    // Largest count a RATIO_WIDTH-bit period counter can hold.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/clk_ratio_monitor_edge_sampler.sv
// Samples the monitored clock as data and flags its rising edges; DIV_CLK_SYNC_EN adds a 2-flop synchronizer.
// Latency: rise_o is high one cycle after capture (three with the synchronizer).
// Backpressure: none.
module edge_sampler
    import clk_mon_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sample_in;
    logic s_cur_q;
    logic s_prev_q;

`ifdef DIV_CLK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sig_i};
        end
    end

    assign sample_in = sync_q[1];
`else
    assign sample_in = sig_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_cur_q  <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            s_cur_q  <= sample_in;
            s_prev_q <= s_cur_q;
        end
    end

    assign rise_o = s_cur_q & ~s_prev_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Recovers the division ratio of i_div_clk in i_ref_clk cycles, with lock and sticky timeout; DIV_CLK_SYNC_EN selects a synchronized input.
// Latency: edge launched at k gives o_ratio_valid in k+2 (k+4 with DIV_CLK_SYNC_EN).
// Backpressure: none; o_ratio_valid is a single-cycle pulse.
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned RATIO_WIDTH = DEF_RATIO_WIDTH,
    parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_mon_en,
    input  logic                   i_div_clk,
    output logic [RATIO_WIDTH-1:0] o_ratio,
    output logic                   o_ratio_valid,
    output logic                   o_locked,
    output logic                   o_timeout
);

    localparam logic [RATIO_WIDTH-1:0] CNT_MAX  = RATIO_WIDTH'(cnt_max(RATIO_WIDTH));
    localparam logic [RATIO_WIDTH-1:0] CNT_ONE  = RATIO_WIDTH'(1);
    localparam logic [2:0]             LOCK_CNT = 3'(LOCK_COUNT);

    mon_state_e             state_q, state_d;
    logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic [2:0]             match_q, match_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;
    logic                   rise;
    logic [2:0]             match_next;

    edge_sampler u_sampler (
        .clk_i  (i_ref_clk),
        .rst_ni (i_rst_n),
        .sig_i  (i_div_clk),
        .rise_o (rise)
    );

    // match_q==0 marks the first measurement after IDLE, which always restarts the run.
    always_comb begin
        match_next = 3'd1;
        if ((match_q != 3'd0) && (cnt_q == ratio_q)) begin
            match_next = (match_q < LOCK_CNT) ? match_q + 3'd1 : LOCK_CNT;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        match_d   = match_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        if (!i_mon_en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            match_d   = 3'd0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        ratio_d   = cnt_q;
                        valid_d   = 1'b1;
                        cnt_d     = CNT_ONE;
                        timeout_d = 1'b0;
                        match_d   = match_next;
                        locked_d  = (match_next >= LOCK_CNT);
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        match_d   = 3'd0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        // Saturation at CNT_MAX is implied: reaching it without an edge is a timeout.
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ratio_q   <= '0;
            match_q   <= 3'd0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_ratio       = ratio_q;
    assign o_ratio_valid = valid_q;
    assign o_locked      = locked_q;
    assign o_timeout     = timeout_q;

endmodule
